input_peripherals: RTL and testbench
====================================

Name: input_peripherals

Overview:
Memory-mapped input side of the board I/O subsystem, the read-direction counterpart to the output peripheral register bank, on the same 8-bit LSU peripheral address bus. It synchronizes the slide switches and synchronizes and debounces the push buttons. It captures button press events in a sticky register that software clears by writing 1s. It raises a maskable level interrupt while any enabled press event is pending.

Parameters:
NUM_SW, 18, number of slide switches (1..32)
NUM_BTN, 4, number of push buttons (1..8)
DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a button change (>=2); counter width $clog2(DEBOUNCE_CYCLES+1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
addr_i  in  8  register address
data_in_i  in  32  write data
write_en_i  in  1  write strobe; effective on the rising clk edge
data_out_o  out  32  combinational read data for addr_i
io_sw_i  in  NUM_SW  raw switches, asynchronous, 1 = on
io_btn_i  in  NUM_BTN  raw buttons, asynchronous, active-low (0 = pressed)
irq_o  out  1  registered interrupt request, level, active-high

Behaviour:
- Register map, all other addresses read 32'd0 and ignore writes:
  - 0x00 SW: read-only; synchronized switches, zero-extended.
  - 0x10 BTN: read-only; debounced button level, 1 = pressed, zero-extended.
  - 0x20 EDGE: sticky press flags; reading returns the flags; writing 1 to a bit clears it (W1C), writing 0 leaves it unchanged.
  - 0x30 MASK: read/write; interrupt enable per button, bits [NUM_BTN-1:0]; upper bits read 0.
- Writes to read-only addresses have no effect.
- Reset (async, reset_n=0): all synchronizer flops 0, button sync flops 1 (released), debounced level 0, all counters 0, EDGE 0, MASK 0, irq_o 0.
- Switch path: two-flop synchronizer per bit. A change on io_sw_i before edge k is visible on the SW read after edge k+1 (2-cycle latency). No debounce on switches.
- Button path, per bit:
  - Two-flop synchronizer followed by inversion gives press_sync.
  - Debounce counter, per button:
    - If press_sync equals stable, the counter is cleared to 0.
    - Otherwise the counter increments each cycle.
    - On the edge where the counter equals DEBOUNCE_CYCLES-1 and the mismatch still holds, stable takes press_sync and the counter clears.
  - Net effect: stable changes exactly DEBOUNCE_CYCLES edges after press_sync first differs, provided the difference persists. Any glitch shorter than that resets the counter and is rejected.
- Edge capture:
  - EDGE[i] is set on the same edge on which stable[i] goes 0->1.
  - A release (1->0) never sets EDGE.
  - When a set and a W1C clear hit the same bit in the same cycle, set wins.
- irq_o: registered each cycle as |(EDGE & MASK), evaluated on the pre-edge register values. It therefore asserts 1 cycle after EDGE or MASK makes the term nonzero, and deasserts 1 cycle after clearing.
- Reads are purely combinational: data_out_o has no read side effects and reflects the current registers for addr_i.
- A write in the same cycle as a read of the same address returns the old value; the new value is visible from the next cycle.
- Reset mid-debounce discards the in-progress count. A button held through reset deassertion is recognized as a fresh press after 2+DEBOUNCE_CYCLES cycles and sets EDGE.

Test Plan:
- Use DEBOUNCE_CYCLES=4 throughout.
- Reset state: reset_n=0 with io_sw_i=18'h3FFFF and io_btn_i=4'h0 -> all reads return 0 and irq_o=0. Deassert reset -> SW reads 32'h3FFFF after 2 edges; BTN reads 32'hF after 6 edges; EDGE reads 32'hF.
- Switch latency: set io_sw_i 0->18'h00A5 -> SW reads 0 after 1 edge and 32'h000000A5 after 2 edges; addresses 0x40 and 0xFF read 0.
- Debounce reject/accept:
  - Pulse io_btn_i[1] low for 3 cycles -> BTN stays 0 and EDGE stays 0.
  - Hold low 20 cycles -> BTN reads 32'h2 exactly 6 edges after the first low sample; EDGE[1]=1.
  - Release -> BTN returns to 0 after 6 edges; EDGE is unchanged.
- W1C: with EDGE=4'hB, write 32'h3 to 0x20 -> EDGE reads 32'h8. Write 32'h0 -> still 32'h8. Write 32'hFFFFFFFF -> 32'h0.
- Set-beats-clear: force a stable 0->1 on button 2 on the same edge as a W1C write of 32'h4 to 0x20 -> EDGE[2]=1 afterwards.
- Interrupt:
  - Write MASK=32'h1 with EDGE=4'h2 -> irq_o stays 0.
  - Press button 0 -> irq_o=1 one cycle after EDGE[0] sets.
  - W1C 32'h1 -> irq_o=0 one cycle later.
  - MASK reads back 32'h1.

Source files
------------

// File: rtl/input_peripherals.sv
`default_nettype none
// ============================================================================
// Module      : input_peripherals
// Description : Memory-mapped input register bank. Synchronizes slide
//               switches, synchronizes and debounces push buttons, latches
//               button press events in a write-1-to-clear register and raises
//               a maskable level interrupt while an enabled event is pending.
// Revision    : 1.0 - initial release
// ============================================================================
module input_peripherals #(
    parameter int NUM_SW          = 18,
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         addr_i,
    input  logic [31:0]        data_in_i,
    input  logic               write_en_i,
    output logic [31:0]        data_out_o,
    input  logic [NUM_SW-1:0]  io_sw_i,
    input  logic [NUM_BTN-1:0] io_btn_i,
    output logic               irq_o
);

    localparam int              c_CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [7:0] c_ADDR_SW   = 8'h00;
    localparam logic [7:0] c_ADDR_BTN  = 8'h10;
    localparam logic [7:0] c_ADDR_EDGE = 8'h20;
    localparam logic [7:0] c_ADDR_MASK = 8'h30;

    logic [NUM_SW-1:0]  r_sw_meta;
    logic [NUM_SW-1:0]  r_sw_sync;
    logic [NUM_BTN-1:0] r_btn_meta;
    logic [NUM_BTN-1:0] r_btn_sync;
    logic [NUM_BTN-1:0] r_stable;
    logic [c_CNT_W-1:0] r_cnt [NUM_BTN];
    logic [NUM_BTN-1:0] r_edge;
    logic [NUM_BTN-1:0] r_mask;

    logic [NUM_BTN-1:0] w_press_sync;
    logic [NUM_BTN-1:0] w_stable_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt [NUM_BTN];
    logic [NUM_BTN-1:0] w_edge_set;
    logic [NUM_BTN-1:0] w_edge_clr;
    logic               w_wr_edge;
    logic               w_wr_mask;
    logic               w_unused_data;

    // Buttons are active-low on the pins; internally 1 means pressed.
    assign w_press_sync = ~r_btn_sync;

    assign w_wr_edge  = write_en_i && (addr_i == c_ADDR_EDGE);
    assign w_wr_mask  = write_en_i && (addr_i == c_ADDR_MASK);
    assign w_edge_clr = w_wr_edge ? data_in_i[NUM_BTN-1:0] : '0;

    // Only press (0->1) transitions of the debounced level raise a flag.
    assign w_edge_set = w_stable_nxt & ~r_stable;

    // Upper write-data bits carry no state in this block.
    assign w_unused_data = ^data_in_i[31:NUM_BTN];

    // Two-flop synchronizers; button flops reset to the released level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_btn_meta <= '1;
            r_btn_sync <= '1;
        end else begin
            r_sw_meta  <= io_sw_i;
            r_sw_sync  <= r_sw_meta;
            r_btn_meta <= io_btn_i;
            r_btn_sync <= r_btn_meta;
        end
    end

    // Debounce: count consecutive mismatch cycles, accept on the last one.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            w_stable_nxt[i] = r_stable[i];
            w_cnt_nxt[i]    = '0;
            if (w_press_sync[i] != r_stable[i]) begin
                if (r_cnt[i] == c_CNT_LAST) begin
                    w_stable_nxt[i] = w_press_sync[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Debounced level and per-button counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_stable <= w_stable_nxt;
            for (int i = 0; i < NUM_BTN; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // Sticky press flags (set wins over W1C), mask, and registered interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge <= '0;
            r_mask <= '0;
            irq_o  <= 1'b0;
        end else begin
            r_edge <= (r_edge & ~w_edge_clr) | w_edge_set;
            if (w_wr_mask) begin
                r_mask <= data_in_i[NUM_BTN-1:0];
            end
            irq_o <= |(r_edge & r_mask);
        end
    end

    // Combinational read mux, zero-extended; unmapped addresses read 0.
    always_comb begin
        data_out_o = '0;
        case (addr_i)
            c_ADDR_SW:   data_out_o[NUM_SW-1:0]  = r_sw_sync;
            c_ADDR_BTN:  data_out_o[NUM_BTN-1:0] = r_stable;
            c_ADDR_EDGE: data_out_o[NUM_BTN-1:0] = r_edge;
            c_ADDR_MASK: data_out_o[NUM_BTN-1:0] = r_mask;
            default:     data_out_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_input_peripherals.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_peripherals
// Description : Directed self-checking bench for input_peripherals with a
//               short debounce window (4 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_peripherals;

    localparam int NUM_SW  = 18;
    localparam int NUM_BTN = 4;
    localparam int DEB     = 4;

    logic               clk;
    logic               reset_n;
    logic [7:0]         addr_i;
    logic [31:0]        data_in_i;
    logic               write_en_i;
    logic [31:0]        data_out_o;
    logic [NUM_SW-1:0]  io_sw_i;
    logic [NUM_BTN-1:0] io_btn_i;
    logic               irq_o;

    int checks = 0;
    int errors = 0;

    input_peripherals #(
        .NUM_SW         (NUM_SW),
        .NUM_BTN        (NUM_BTN),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .addr_i    (addr_i),
        .data_in_i (data_in_i),
        .write_en_i(write_en_i),
        .data_out_o(data_out_o),
        .io_sw_i   (io_sw_i),
        .io_btn_i  (io_btn_i),
        .irq_o     (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [7:0] a, input string tag, input logic [31:0] exp);
        addr_i = a;
        #1;
        chk(tag, data_out_o, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        addr_i     = a;
        data_in_i  = d;
        write_en_i = 1'b1;
        tick(1);
        write_en_i = 1'b0;
        data_in_i  = 32'h0;
    endtask

    // Hard time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n    = 1'b0;
        addr_i     = 8'h00;
        data_in_i  = 32'h0;
        write_en_i = 1'b0;
        io_sw_i    = 18'h3FFFF;
        io_btn_i   = 4'h0;

        // Reset state
        tick(2);
        rd(8'h00, "rst_sw", 32'h0);
        rd(8'h10, "rst_btn", 32'h0);
        rd(8'h20, "rst_edge", 32'h0);
        rd(8'h30, "rst_mask", 32'h0);
        chk("rst_irq", {31'b0, irq_o}, 32'h0);

        // Release reset with switches on and all buttons held down
        reset_n = 1'b1;
        tick(1);
        rd(8'h00, "sw_1edge", 32'h0);
        tick(1);
        rd(8'h00, "sw_2edge", 32'h3FFFF);
        tick(3);
        rd(8'h10, "btn_5edge", 32'h0);
        tick(1);
        rd(8'h10, "btn_6edge", 32'hF);
        rd(8'h20, "edge_held_rst", 32'hF);

        // Release all buttons; level drops, flags stay
        io_btn_i = 4'hF;
        tick(7);
        rd(8'h10, "btn_released", 32'h0);
        rd(8'h20, "edge_after_rel", 32'hF);
        wr(8'h20, 32'hFFFF_FFFF);
        rd(8'h20, "edge_clr_all", 32'h0);

        // Switch latency and unmapped addresses
        io_sw_i = '0;
        tick(3);
        rd(8'h00, "sw_zero", 32'h0);
        io_sw_i = 18'h000A5;
        tick(1);
        rd(8'h00, "sw_lat1", 32'h0);
        tick(1);
        rd(8'h00, "sw_lat2", 32'h000000A5);
        rd(8'h40, "unmapped_40", 32'h0);
        rd(8'hFF, "unmapped_ff", 32'h0);
        wr(8'h00, 32'h0);
        rd(8'h00, "sw_ro_write", 32'h000000A5);

        // Glitch of 3 cycles on button 1 is rejected
        io_btn_i = 4'hD;
        tick(3);
        io_btn_i = 4'hF;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            rd(8'h10, "glitch_btn", 32'h0);
        end
        rd(8'h20, "glitch_edge", 32'h0);

        // Hold button 1 for 20 cycles
        io_btn_i = 4'hD;
        tick(5);
        rd(8'h10, "hold_btn_5", 32'h0);
        rd(8'h20, "hold_edge_5", 32'h0);
        tick(1);
        rd(8'h10, "hold_btn_6", 32'h2);
        rd(8'h20, "hold_edge_6", 32'h2);
        tick(14);
        io_btn_i = 4'hF;
        tick(5);
        rd(8'h10, "rel_btn_5", 32'h2);
        tick(1);
        rd(8'h10, "rel_btn_6", 32'h0);
        rd(8'h20, "rel_edge", 32'h2);

        // Press buttons 0 and 3 to reach EDGE = 0xB
        io_btn_i = 4'h6;
        tick(6);
        io_btn_i = 4'hF;
        tick(7);
        rd(8'h20, "edge_b", 32'hB);

        // W1C; read during the write cycle still shows the old value
        addr_i     = 8'h20;
        data_in_i  = 32'h3;
        write_en_i = 1'b1;
        #1;
        chk("w1c_same_cycle", data_out_o, 32'hB);
        tick(1);
        write_en_i = 1'b0;
        data_in_i  = 32'h0;
        rd(8'h20, "w1c_3", 32'h8);
        wr(8'h20, 32'h0);
        rd(8'h20, "w1c_0", 32'h8);
        wr(8'h20, 32'hFFFF_FFFF);
        rd(8'h20, "w1c_all", 32'h0);

        // Set beats clear: button 2 rises on the same edge as W1C of bit 2
        io_btn_i = 4'hB;
        tick(5);
        rd(8'h20, "sbc_before", 32'h0);
        wr(8'h20, 32'h4);
        rd(8'h20, "sbc_after", 32'h4);
        io_btn_i = 4'hF;
        tick(7);
        wr(8'h20, 32'hFFFF_FFFF);
        rd(8'h20, "sbc_cleared", 32'h0);

        // Interrupt: EDGE = 0x2 with MASK = 0x1 keeps irq low
        io_btn_i = 4'hD;
        tick(6);
        io_btn_i = 4'hF;
        tick(7);
        rd(8'h20, "irq_edge2", 32'h2);
        wr(8'h30, 32'h1);
        chk("irq_masked_0", {31'b0, irq_o}, 32'h0);
        tick(2);
        chk("irq_masked_2", {31'b0, irq_o}, 32'h0);
        rd(8'h30, "mask_rb", 32'h1);

        // Press button 0: irq follows EDGE[0] by one cycle
        io_btn_i = 4'hE;
        tick(6);
        rd(8'h20, "irq_edge3", 32'h3);
        chk("irq_same_edge", {31'b0, irq_o}, 32'h0);
        tick(1);
        chk("irq_asserted", {31'b0, irq_o}, 32'h1);
        io_btn_i = 4'hF;
        wr(8'h20, 32'h1);
        rd(8'h20, "irq_w1c_edge", 32'h2);
        chk("irq_w1c_lag", {31'b0, irq_o}, 32'h1);
        tick(1);
        chk("irq_deasserted", {31'b0, irq_o}, 32'h0);
        rd(8'h30, "mask_final", 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
